// File: rtl/i2c_target_responder_if.sv
// i2c_target_responder_if
// Groups the I2C pin-side and byte-side signals of the target responder.
//   SCL_IN, SDA_IN : raw bus pin levels seen by the target
//   SDA_OE         : 1 = target pulls SDA low, 0 = released (external pull-up)
//   RX_DATA        : last byte written by the master, MSB first on the wire
//   RX_VALID       : one-CLK pulse when RX_DATA is updated
//   TX_DATA        : byte the target sends on the next read byte
//   TX_REQ         : one-CLK pulse when TX_DATA has been captured
//   BUSY           : high from address match until STOP/NACK/mismatch exit
//   RW_DIR         : R/W bit of the last matched address (1 = master reads)
// Byte-side handshake: there is no back-pressure. RX_VALID qualifies RX_DATA
// for exactly one CLK and the consumer must take it then. TX_REQ marks the
// CLK on which TX_DATA was sampled; the producer may change TX_DATA freely
// after that pulse and must have the next byte stable before the next one.
interface i2c_target_responder_if;
  logic       SCL_IN;
  logic       SDA_IN;
  logic       SDA_OE;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [7:0] TX_DATA;
  logic       TX_REQ;
  logic       BUSY;
  logic       RW_DIR;

  // Target side (the responder itself).
  modport slave (
    input  SCL_IN, SDA_IN, TX_DATA,
    output SDA_OE, RX_DATA, RX_VALID, TX_REQ, BUSY, RW_DIR
  );

  // Bus/system side (pins, byte source and sink).
  modport master (
    output SCL_IN, SDA_IN, TX_DATA,
    input  SDA_OE, RX_DATA, RX_VALID, TX_REQ, BUSY, RW_DIR
  );
endinterface

// File: rtl/i2c_target_responder.sv
// i2c_target_responder
// I2C target that oversamples SCL/SDA on CLK, detects START/repeated
// START/STOP, answers SLAVE_ADDR, receives write bytes and transmits read
// bytes. SDA is open-drain through SDA_OE; SCL is never driven.
// Ports:
//   CLK       : system clock, all logic on posedge
//   RST       : synchronous active-high reset
//   bus       : i2c_target_responder_if.slave (pins and byte interface)
//   STATE_DBG : current FSM state code
//               0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 WR_BYTE, 4 WR_ACK,
//               5 RD_BYTE, 6 RD_ACK, 7 WAIT_STOP
module i2c_target_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h26,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  i2c_target_responder_if.slave   bus,
  output logic [2:0]              STATE_DBG
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_BYTE   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_BYTE   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  // Synchronizers preset to 1 so reset looks like an idle bus.
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.SCL_IN};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.SDA_IN};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_evt;
  logic stop_evt;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SDA edges while SCL is high are bus conditions, never data.
  assign start_evt = scl_s & sda_d & ~sda_s;
  assign stop_evt  = scl_s & ~sda_d & sda_s;

  logic [2:0] state;
  logic [7:0] shifter;
  logic [3:0] bit_cnt;
  // ADDR_ACK/WR_ACK: set once the ACK low has been driven.
  // RD_ACK: set once the master ACK has been sampled.
  logic       ack_flag;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       rw_dir;
  logic [7:0] shift_nxt;

  assign shift_nxt = {shifter[6:0], sda_s};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      shifter  <= 8'h00;
      bit_cnt  <= 4'd0;
      ack_flag <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      rw_dir   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_evt) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        bit_cnt  <= 4'd0;
        ack_flag <= 1'b0;
      end else if (start_evt) begin
        state    <= ADDR;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        bit_cnt  <= 4'd0;
        ack_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end

          ADDR: begin
            if (scl_rise) begin
              shifter <= shift_nxt;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                // shifter[6:0] holds the 7 address bits, sda_s is R/W.
                if (shifter[6:0] == SLAVE_ADDR) begin
                  rw_dir   <= sda_s;
                  busy     <= 1'b1;
                  ack_flag <= 1'b0;
                  state    <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_flag) begin
                sda_oe   <= 1'b1;
                ack_flag <= 1'b1;
              end else begin
                ack_flag <= 1'b0;
                bit_cnt  <= 4'd0;
                if (!rw_dir) begin
                  sda_oe <= 1'b0;
                  state  <= WR_BYTE;
                end else begin
                  shifter <= bus.TX_DATA;
                  tx_req  <= 1'b1;
                  sda_oe  <= ~bus.TX_DATA[7];
                  state   <= RD_BYTE;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shifter <= shift_nxt;
              if (bit_cnt == 4'd7) begin
                bit_cnt  <= 4'd0;
                rx_data  <= shift_nxt;
                rx_valid <= 1'b1;
                ack_flag <= 1'b0;
                state    <= WR_ACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_flag) begin
                sda_oe   <= 1'b1;
                ack_flag <= 1'b1;
              end else begin
                sda_oe   <= 1'b0;
                ack_flag <= 1'b0;
                state    <= WR_BYTE;
              end
            end
          end

          RD_BYTE: begin
            // Bit 7 is already on the wire at entry; rises count bits out,
            // falls shift the next bit onto the wire.
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe   <= 1'b0;
                bit_cnt  <= 4'd0;
                ack_flag <= 1'b0;
                state    <= RD_ACK;
              end else begin
                shifter <= {shifter[6:0], 1'b0};
                sda_oe  <= ~shifter[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_flag <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end else if (scl_fall && ack_flag) begin
              ack_flag <= 1'b0;
              bit_cnt  <= 4'd0;
              shifter  <= bus.TX_DATA;
              tx_req   <= 1'b1;
              sda_oe   <= ~bus.TX_DATA[7];
              state    <= RD_BYTE;
            end
          end

          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.SDA_OE   = sda_oe;
  assign bus.RX_DATA  = rx_data;
  assign bus.RX_VALID = rx_valid;
  assign bus.TX_REQ   = tx_req;
  assign bus.BUSY     = busy;
  assign bus.RW_DIR   = rw_dir;
  assign STATE_DBG    = state;

endmodule
